baby_vga_scan_gen: RTL and testbench

//  Scan/timing generator feeding the baby VGA framebuffer and pixel output stage. Walks the

---
 rtl/baby_vga_scan_gen_if.sv | 22 ++
 rtl/baby_vga_scan_gen.sv | 145 ++++++++++++++
 tb/tb_baby_vga_scan_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/baby_vga_scan_gen_if.sv
// Scan generator bus: prescaler/interrupt-clear controls in, timing and grid coordinates out.
interface baby_vga_scan_gen_if;
    logic [3:0] clk_div;
    logic       cli;
    logic [4:0] x_pos;
    logic [3:0] y_pos;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic [2:0] phase;
    logic       interrupt;

    modport master (
        output clk_div, cli,
        input  x_pos, y_pos, hsync, vsync, blank, phase, interrupt
    );

    modport slave (
        input  clk_div, cli,
        output x_pos, y_pos, hsync, vsync, blank, phase, interrupt
    );
endinterface

// File: rtl/baby_vga_scan_gen.sv
// VGA scan/timing generator: prescaled pixel tick, h/v counters, registered syncs/blank,
// 32x16 coarse grid coordinates and a sticky vertical-blank interrupt.
module baby_vga_scan_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    baby_vga_scan_gen_if.slave  bus
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int COL_PIX   = H_ACTIVE / 32;
    localparam int ROW_LINES = V_ACTIVE / 16;

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] COL_LAST = 11'(COL_PIX - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  ROW_LAST = 10'(ROW_LINES - 1);

    logic        tick;
    logic [3:0]  pre_q, pre_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [4:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic        irq_q, irq_d;

    logic [4:0]  x_pos_q, x_pos_d;
    logic [3:0]  y_pos_q, y_pos_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic [2:0]  phase_q, phase_d;

    // >= rather than == so that lowering clk_div mid-count ticks immediately instead of wrapping.
    always_comb begin
        tick    = (pre_q >= bus.clk_div);
        pre_d   = tick ? 4'd0 : pre_q + 4'd1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        irq_d   = bus.cli ? 1'b0 : irq_q;

        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                col_d   = '0;
                x_d     = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                    row_d   = '0;
                    y_d     = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (y_q != 4'd15) y_d = y_q + 4'd1;
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                    // Set after the cli clear so a coincident set wins.
                    if (v_cnt_q == V_ACT - 10'd1) irq_d = 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (x_q != 5'd31) x_d = x_q + 5'd1;
                end else begin
                    col_d = col_q + 11'd1;
                end
            end
        end
    end

    always_comb begin
        blank_d = !((h_cnt_q < H_ACT) && (v_cnt_q < V_ACT));
        hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        phase_d = h_cnt_q[2:0];
        x_pos_d = x_q;
        y_pos_d = y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            irq_q   <= 1'b0;
            x_pos_q <= '0;
            y_pos_q <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            blank_q <= 1'b1;
            phase_q <= '0;
        end else begin
            pre_q   <= pre_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            irq_q   <= irq_d;
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            phase_q <= phase_d;
        end
    end

    assign bus.x_pos     = x_pos_q;
    assign bus.y_pos     = y_pos_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.blank     = blank_q;
    assign bus.phase     = phase_q;
    assign bus.interrupt = irq_q;
endmodule

// File: tb/tb_baby_vga_scan_gen.sv
// Directed bench: full-size timing for line-level behaviour, a scaled-down instance for frame-level.
module tb_baby_vga_scan_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    baby_vga_scan_gen_if bus();
    baby_vga_scan_gen_if sbus();

    baby_vga_scan_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scaled timing: 80 clocks/line, 40 lines/frame, 2 pixels/column, 2 lines/row.
    baby_vga_scan_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(3), .V_BP(3)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst released just after an edge: the next step() is the first counting edge.
    task automatic restart(input logic [3:0] div);
        rst = 1'b1;
        bus.clk_div = div;
        sbus.clk_div = div;
        bus.cli = 1'b0;
        sbus.cli = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        restart(4'd0);
        repeat (700) step();
        rst = 1'b1;
        step();
        total++; if (bus.x_pos !== 5'd0) $display("FAIL reset_x_pos got %0d want 0", bus.x_pos); else passed++;
        total++; if (bus.y_pos !== 4'd0) $display("FAIL reset_y_pos got %0d want 0", bus.y_pos); else passed++;
        total++; if (bus.hsync !== 1'b1) $display("FAIL reset_hsync got %b want 1", bus.hsync); else passed++;
        total++; if (bus.vsync !== 1'b1) $display("FAIL reset_vsync got %b want 1", bus.vsync); else passed++;
        total++; if (bus.blank !== 1'b1) $display("FAIL reset_blank got %b want 1", bus.blank); else passed++;
        total++; if (bus.phase !== 3'd0) $display("FAIL reset_phase got %0d want 0", bus.phase); else passed++;
        total++; if (bus.interrupt !== 1'b0) $display("FAIL reset_interrupt got %b want 0", bus.interrupt); else passed++;
        total++; if (sbus.blank !== 1'b1) $display("FAIL reset_small_blank got %b want 1", sbus.blank); else passed++;
        step();
        step();
        rst = 1'b0;
        step();
        total++; if (bus.blank !== 1'b0 || bus.phase !== 3'd0 || bus.x_pos !== 5'd0)
            $display("FAIL reset_restart got blank=%b phase=%0d x=%0d want 0/0/0", bus.blank, bus.phase, bus.x_pos);
        else passed++;
    endtask

    task automatic test_hline();
        int first_fall = -1;
        int second_fall = -1;
        int low_cnt = 0;
        int blank_lo = 0;
        int bad = 0;
        string bad_msg = "";
        logic prev_hs = 1'b1;
        restart(4'd0);
        for (int n = 1; n <= 2700; n++) begin
            int h;
            logic eb, eh;
            logic [4:0] ex;
            logic [2:0] ep;
            step();
            h  = (n - 1) % 1344;
            eb = (h >= 1024);
            eh = !(h >= 1048 && h < 1184);
            ex = (h < 1024) ? 5'(h / 32) : 5'd31;
            ep = 3'(h % 8);
            if (bus.blank !== eb || bus.hsync !== eh || bus.vsync !== 1'b1 ||
                bus.x_pos !== ex || bus.y_pos !== 4'd0 || bus.phase !== ep) begin
                if (bad == 0)
                    bad_msg = $sformatf("n=%0d got b/hs/vs/x/y/ph=%b/%b/%b/%0d/%0d/%0d want %b/%b/1/%0d/0/%0d",
                        n, bus.blank, bus.hsync, bus.vsync, bus.x_pos, bus.y_pos, bus.phase, eb, eh, ex, ep);
                bad++;
            end
            if (prev_hs && !bus.hsync) begin
                if (first_fall < 0) first_fall = n;
                else if (second_fall < 0) second_fall = n;
            end
            if (!bus.hsync && first_fall > 0 && second_fall < 0) low_cnt++;
            if (!bus.blank && n <= 1344) blank_lo++;
            prev_hs = bus.hsync;
        end
        total++; if (bad != 0) $display("FAIL hline_sweep errors=%0d first %s", bad, bad_msg); else passed++;
        total++; if (blank_lo != 1024) $display("FAIL hline_active_len got %0d want 1024", blank_lo); else passed++;
        total++; if (first_fall != 1049) $display("FAIL hline_hsync_start got %0d want 1049", first_fall); else passed++;
        total++; if (low_cnt != 136) $display("FAIL hline_hsync_width got %0d want 136", low_cnt); else passed++;
        total++; if (second_fall != 2393) $display("FAIL hline_period got %0d want 2393", second_fall); else passed++;
    endtask

    task automatic test_clkdiv();
        int first_fall = -1;
        int second_fall = -1;
        int low_cnt = 0;
        logic prev_hs = 1'b1;
        restart(4'd1);
        for (int n = 1; n <= 4800; n++) begin
            step();
            if (prev_hs && !bus.hsync) begin
                if (first_fall < 0) first_fall = n;
                else if (second_fall < 0) second_fall = n;
            end
            if (!bus.hsync && first_fall > 0 && second_fall < 0) low_cnt++;
            prev_hs = bus.hsync;
        end
        total++; if (first_fall != 2097) $display("FAIL div1_hsync_start got %0d want 2097", first_fall); else passed++;
        total++; if (low_cnt != 272) $display("FAIL div1_hsync_width got %0d want 272", low_cnt); else passed++;
        total++; if (second_fall - first_fall != 2688)
            $display("FAIL div1_line_period got %0d want 2688", second_fall - first_fall); else passed++;
    endtask

    task automatic test_div_switch();
        restart(4'd9);
        repeat (10) step();
        total++; if (bus.phase !== 3'd0) $display("FAIL div9_phase_n10 got %0d want 0", bus.phase); else passed++;
        step();
        total++; if (bus.phase !== 3'd1) $display("FAIL div9_phase_n11 got %0d want 1", bus.phase); else passed++;
        repeat (4) step();
        bus.clk_div = 4'd0;
        step();
        step();
        total++; if (bus.phase !== 3'd2) $display("FAIL div_switch_first got %0d want 2", bus.phase); else passed++;
        step();
        total++; if (bus.phase !== 3'd3) $display("FAIL div_switch_second got %0d want 3", bus.phase); else passed++;
    endtask

    task automatic test_vframe();
        int bad = 0;
        int vs_first = -1;
        int vs_cnt = 0;
        string bad_msg = "";
        logic prev_vs = 1'b1;
        restart(4'd0);
        for (int n = 1; n <= 6000; n++) begin
            int h, v;
            logic eb, eh, ev, ei;
            logic [4:0] ex;
            logic [3:0] ey;
            step();
            h  = (n - 1) % 80;
            v  = ((n - 1) / 80) % 40;
            eb = !(h < 64 && v < 32);
            eh = !(h >= 68 && h < 76);
            ev = !(v >= 34 && v < 37);
            ex = (h < 64) ? 5'(h / 2) : 5'd31;
            ey = (v < 32) ? 4'(v / 2) : 4'd15;
            ei = (n >= 2560 && n <= 2600) || (n >= 5760);
            if (sbus.blank !== eb || sbus.hsync !== eh || sbus.vsync !== ev ||
                sbus.x_pos !== ex || sbus.y_pos !== ey || sbus.interrupt !== ei) begin
                if (bad == 0)
                    bad_msg = $sformatf("n=%0d got b/hs/vs/x/y/irq=%b/%b/%b/%0d/%0d/%b want %b/%b/%b/%0d/%0d/%b",
                        n, sbus.blank, sbus.hsync, sbus.vsync, sbus.x_pos, sbus.y_pos, sbus.interrupt,
                        eb, eh, ev, ex, ey, ei);
                bad++;
            end
            if (prev_vs && !sbus.vsync && vs_first < 0) vs_first = n;
            if (!sbus.vsync && n <= 3200) vs_cnt++;
            prev_vs = sbus.vsync;
            if (n == 2559) begin
                total++; if (sbus.interrupt !== 1'b0) $display("FAIL irq_before_set got %b want 0", sbus.interrupt); else passed++;
            end
            if (n == 2560) begin
                total++; if (sbus.interrupt !== 1'b1) $display("FAIL irq_set got %b want 1", sbus.interrupt); else passed++;
            end
            if (n == 2600) sbus.cli = 1'b1;
            if (n == 2601) begin
                sbus.cli = 1'b0;
                total++; if (sbus.interrupt !== 1'b0) $display("FAIL irq_cli got %b want 0", sbus.interrupt); else passed++;
            end
            if (n == 5759) sbus.cli = 1'b1;
            if (n == 5760) begin
                sbus.cli = 1'b0;
                total++; if (sbus.interrupt !== 1'b1) $display("FAIL irq_set_wins got %b want 1", sbus.interrupt); else passed++;
            end
            if (n == 5761) begin
                total++; if (sbus.interrupt !== 1'b1) $display("FAIL irq_sticky got %b want 1", sbus.interrupt); else passed++;
            end
        end
        total++; if (bad != 0) $display("FAIL vframe_sweep errors=%0d first %s", bad, bad_msg); else passed++;
        total++; if (vs_first != 2721) $display("FAIL vsync_start got %0d want 2721", vs_first); else passed++;
        total++; if (vs_cnt != 240) $display("FAIL vsync_width got %0d want 240", vs_cnt); else passed++;
    endtask

    initial begin
        bus.clk_div = 4'd0;
        bus.cli = 1'b0;
        sbus.clk_div = 4'd0;
        sbus.cli = 1'b0;
        test_reset();
        test_hline();
        test_clkdiv();
        test_div_switch();
        test_vframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
